h75_frame_scheduler: RTL
========================

Name: h75_frame_scheduler

Overview:
Sequencing controller for the HUB75 timing generator and its double-buffered pixel RAM. It issues frame-start requests (gen_timing) at a programmable frame period and detects frame starts from the generator's frame_sync. It owns front/back buffer selection and applies software swap requests only at frame boundaries, so a displayed frame never tears. It also keeps frame and overrun statistics for the CPU register interface.

Parameters:
PERIOD_W, 24, width of frame period counter
ADDR_W, 14, width of generator read address ({row, x})
STAT_W, 16, width of frame_count

Ports:
clk  in  1  system clock (20 ns)
resetn  in  1  asynchronous active-low reset
enable  in  1  level; 1 = schedule frames
frame_period  in  PERIOD_W  clocks per frame; 1,000,000 = 50 Hz
swap_req  in  1  single-cycle pulse: swap front/back at next frame start
clear_stats  in  1  single-cycle pulse: zero frame_count and overrun_count
frame_sync  in  1  from timing generator; rising edge = frame started
rd_addr_in  in  ADDR_W  read address from timing generator
gen_timing  out  1  frame request level to timing generator
buf_rd_addr  out  ADDR_W+1  {front_buf, rd_addr_in} to pixel RAM, combinational
front_buf  out  1  buffer currently displayed
back_buf  out  1  ~front_buf, buffer the writer may fill
swap_pending  out  1  swap requested, not yet applied
swap_done  out  1  one-cycle pulse when swap applied
frame_count  out  STAT_W  frames started, wraps
overrun_count  out  8  periods elapsed with request unacknowledged, saturates at 255

Behaviour:
- Reset values: all outputs 0 (back_buf = 1), state S_OFF, period counter = 0, fs_d = 0.
- Clock and reset: the single clock is clk. resetn is asynchronous and active-low; it returns every register to its reset value. A reset mid-frame drops gen_timing immediately; the generator's own reset governs its state.
- Edge detect: fs_d registers frame_sync; rise = frame_sync & ~fs_d (one-cycle detection latency).
- Period timer:
  - Down-counter, loaded with frame_period-1 on entry to S_ARM from S_OFF and on every tick.
  - tick = (count == 0) while enable = 1.
  - frame_period is sampled only at reload.
  - frame_period = 0 or 1 means tick every cycle (free-running: gen_timing stays high).
- FSM:
  - S_OFF: gen_timing = 0. On enable = 1, go to S_ARM and load the counter.
  - S_ARM: gen_timing = 1.
    - rise: go to S_RUN.
    - tick without rise: overrun_count += 1 (saturating), stay in S_ARM.
    - rise and tick in the same cycle: go to S_ARM, no overrun.
  - S_RUN: gen_timing = 0. tick: go to S_ARM.
  - enable = 0 in any state: go to S_OFF next cycle and gen_timing drops. The generator completes the frame already in progress; no abort.
  - Latency: gen_timing rises the cycle after a tick or after enable, and falls the cycle after rise.
- Frame statistics: rise increments frame_count in every state, including S_OFF, because the generator may still be finishing a frame.
- Swap logic:
  - On rise with swap_pending = 1: front_buf toggles, swap_done pulses for 1 cycle, swap_pending clears.
  - swap_req with no rise: swap_pending set; a repeated request while pending is ignored.
  - swap_req coincident with rise:
    - if pending = 0, the request latches for the NEXT frame;
    - if pending = 1, the swap applies and swap_pending stays 1.
  - swap_req while disabled latches and applies at the first frame after re-enable.
  - The buffer bit changes at least 10 cycles before the generator's first read (generator start delay), so mid-frame address change is impossible.
- clear_stats: zeros both counters. It wins over a coincident increment.
- Widths: counters wrap modulo 2^STAT_W except overrun_count (saturating). All comparisons are unsigned.

Decomposition:
- Package h75_pkg: FSM state encoding (S_OFF = 0, S_ARM = 1, S_RUN = 2), PERIOD_W, ADDR_W, STAT_W, and DEFAULT_FRAME_PERIOD = 1000000 (50 Hz at 20 ns).
- One sub-module, h75_period_timer: reloadable down-counter with load, enable, period in, and tick out.
- Swap, statistics and FSM logic stay in the top module.

Test Plan:
- Reset, then enable = 1 with frame_period = 100 and a model that returns frame_sync 3 cycles after gen_timing:
  - gen_timing rises 1 cycle after enable and falls 1 cycle after the frame_sync rise;
  - successive gen_timing rises are exactly 100 cycles apart;
  - frame_count = 5 after 5 frames.
- Swap: swap_req pulse mid-frame gives swap_pending = 1. At the next rise, front_buf goes 0→1, swap_done is high for 1 cycle and swap_pending returns to 0. With rd_addr_in = 0x1234, buf_rd_addr changes 0x1234 → 0x5234 and back_buf = 0.
- Overrun: frame_sync held low with frame_period = 50. After 150 cycles, overrun_count = 3 and gen_timing is still high. With frame_sync held low for 300 periods, overrun_count = 255 (saturated).
- Disable and re-enable:
  - enable drops mid-S_RUN: gen_timing = 0 and stays 0 for 500 cycles;
  - a frame_sync rise during that time still increments frame_count;
  - swap_req while disabled gives swap_pending = 1, and front_buf toggles on the first rise after re-enable.
- Simultaneous events:
  - swap_req on the same cycle as rise with pending = 1: front_buf toggles once and pending stays 1; the next frame toggles again;
  - clear_stats on the same cycle as rise: frame_count = 0.
- Free-running: frame_period = 0 keeps gen_timing = 1 continuously in S_ARM; no overruns are counted while the model acknowledges every 40 cycles and the 40-cycle period is honoured.

Source files
------------

// File: rtl/h75_pkg.sv
// h75_pkg - shared definitions for the HUB75 frame scheduler.
//   PERIOD_W / ADDR_W / STAT_W : default widths of period counter, generator
//                                read address and frame counter
//   OVR_W                      : width of the saturating overrun counter
//   DEFAULT_FRAME_PERIOD       : 50 Hz frame rate at a 20 ns clock
//   h75_state_t                : scheduler FSM encoding
//   sat_inc                    : saturating increment for the overrun counter
package h75_pkg;

    localparam int PERIOD_W             = 24;
    localparam int ADDR_W               = 14;
    localparam int STAT_W               = 16;
    localparam int OVR_W                = 8;
    localparam int DEFAULT_FRAME_PERIOD = 1000000;

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_ARM = 2'd1,
        S_RUN = 2'd2
    } h75_state_t;

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] value);
        return (value == '1) ? value : value + OVR_W'(1);
    endfunction

endpackage

// File: rtl/h75_period_timer.sv
// h75_period_timer - reloadable frame period down-counter.
//   clk, resetn : clock, asynchronous active-low reset
//   load        : reload from period (takes priority over counting)
//   run         : count enable; tick is only produced while run = 1
//   period      : clocks per frame, sampled only on reload
//   tick        : high for one cycle when the count reaches zero
//   free_run    : the last sampled period was 0 or 1 (tick every cycle)
module h75_period_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                load,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick,
    output logic                free_run
);

    logic [PERIOD_W-1:0] count_reg;
    logic                free_run_reg;
    logic                reload;

    assign tick     = run & ~load & (count_reg == '0);
    assign reload   = load | tick;
    assign free_run = free_run_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg    <= '0;
            free_run_reg <= 1'b0;
        end else if (reload) begin
            // A period of 0 behaves like 1: the count stays at zero.
            count_reg    <= (period == '0) ? '0 : period - PERIOD_W'(1);
            free_run_reg <= (period <= PERIOD_W'(1));
        end else if (run && count_reg != '0) begin
            count_reg <= count_reg - PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/h75_frame_scheduler.sv
// h75_frame_scheduler - frame sequencing for the HUB75 timing generator and
// its double-buffered pixel RAM.
//   clk, resetn    : clock, asynchronous active-low reset
//   enable         : level, 1 = schedule frames
//   frame_period   : clocks per frame (sampled at timer reload)
//   swap_req       : pulse, swap front/back buffer at the next frame start
//   clear_stats    : pulse, zero frame_count and overrun_count
//   frame_sync     : from generator, rising edge = frame started
//   rd_addr_in     : generator read address {row, x}
//   gen_timing     : frame request level to the generator
//   buf_rd_addr    : {front_buf, rd_addr_in} to the pixel RAM
//   front_buf      : buffer being displayed; back_buf = ~front_buf
//   swap_pending   : swap requested but not yet applied
//   swap_done      : one-cycle pulse when a swap is applied
//   frame_count    : frames started (wraps)
//   overrun_count  : periods expired with the request unacknowledged (saturates)
module h75_frame_scheduler #(
    parameter int PERIOD_W = h75_pkg::PERIOD_W,
    parameter int ADDR_W   = h75_pkg::ADDR_W,
    parameter int STAT_W   = h75_pkg::STAT_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] frame_period,
    input  logic                swap_req,
    input  logic                clear_stats,
    input  logic                frame_sync,
    input  logic [ADDR_W-1:0]   rd_addr_in,
    output logic                gen_timing,
    output logic [ADDR_W:0]     buf_rd_addr,
    output logic                front_buf,
    output logic                back_buf,
    output logic                swap_pending,
    output logic                swap_done,
    output logic [STAT_W-1:0]   frame_count,
    output logic [7:0]          overrun_count
);

    import h75_pkg::*;

    h75_state_t        state_reg;
    logic              gen_timing_reg;
    logic              fs_d_reg;
    logic              front_buf_reg;
    logic              swap_pending_reg;
    logic              swap_done_reg;
    logic [STAT_W-1:0] frame_count_reg;
    logic [7:0]        overrun_count_reg;

    logic rise;
    logic tick;
    logic free_run;
    logic timer_load;
    logic timer_run;
    logic overrun_hit;

    assign rise       = frame_sync & ~fs_d_reg;
    assign timer_load = (state_reg == S_OFF) & enable;
    assign timer_run  = (state_reg != S_OFF) & enable;
    // With a free-running period the generator itself paces the frames, so
    // an unanswered tick is not an overrun there.
    assign overrun_hit = (state_reg == S_ARM) & tick & ~rise & ~free_run;

    h75_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (timer_load),
        .run      (timer_run),
        .period   (frame_period),
        .tick     (tick),
        .free_run (free_run)
    );

    // Scheduler FSM with registered frame request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= S_OFF;
            gen_timing_reg <= 1'b0;
        end else if (!enable) begin
            state_reg      <= S_OFF;
            gen_timing_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_OFF: begin
                    state_reg      <= S_ARM;
                    gen_timing_reg <= 1'b1;
                end
                S_ARM: begin
                    // A frame start coinciding with a tick re-arms at once.
                    if (rise && !tick) begin
                        state_reg      <= S_RUN;
                        gen_timing_reg <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        state_reg      <= S_ARM;
                        gen_timing_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= S_OFF;
                    gen_timing_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_d_reg <= 1'b0;
        end else begin
            fs_d_reg <= frame_sync;
        end
    end

    // Buffer swap: applied only on a frame start. A request arriving with
    // that frame start always carries over to the following frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            front_buf_reg    <= 1'b0;
            swap_pending_reg <= 1'b0;
            swap_done_reg    <= 1'b0;
        end else begin
            swap_done_reg    <= rise & swap_pending_reg;
            swap_pending_reg <= swap_req | (swap_pending_reg & ~rise);
            if (rise && swap_pending_reg) begin
                front_buf_reg <= ~front_buf_reg;
            end
        end
    end

    // Statistics; clear wins over a coincident increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_count_reg   <= '0;
            overrun_count_reg <= '0;
        end else if (clear_stats) begin
            frame_count_reg   <= '0;
            overrun_count_reg <= '0;
        end else begin
            if (rise) begin
                frame_count_reg <= frame_count_reg + STAT_W'(1);
            end
            if (overrun_hit) begin
                overrun_count_reg <= sat_inc(overrun_count_reg);
            end
        end
    end

    assign gen_timing    = gen_timing_reg;
    assign front_buf     = front_buf_reg;
    assign back_buf      = ~front_buf_reg;
    assign buf_rd_addr   = {front_buf_reg, rd_addr_in};
    assign swap_pending  = swap_pending_reg;
    assign swap_done     = swap_done_reg;
    assign frame_count   = frame_count_reg;
    assign overrun_count = overrun_count_reg;

endmodule
